// File: rtl/sorter_pkg.sv
// Shared definitions for the package sorter: group codes, default chute
// distances, gate hold time and the in-flight slot record.
package sorter_pkg;

  localparam logic [2:0] GRP_NONE = 3'd0;
  localparam logic [2:0] GRP1     = 3'd1;
  localparam logic [2:0] GRP2     = 3'd2;
  localparam logic [2:0] GRP3     = 3'd3;
  localparam logic [2:0] GRP4     = 3'd4;
  localparam logic [2:0] GRP5     = 3'd5;
  localparam logic [2:0] GRP6     = 3'd6;

  localparam int unsigned NCHUTES = 6;
  localparam int unsigned STEP_W  = 8;
  localparam int unsigned TIMER_W = 4;

  localparam int unsigned D1_DEF = 4;
  localparam int unsigned D2_DEF = 8;
  localparam int unsigned D3_DEF = 12;
  localparam int unsigned D4_DEF = 16;
  localparam int unsigned D5_DEF = 20;
  localparam int unsigned D6_DEF = 24;

  localparam int unsigned GATE_CYCLES_DEF = 3;

  typedef struct packed {
    logic              valid;
    logic [2:0]        grp;
    logic [STEP_W-1:0] steps;
  } slot_t;

  // Groups 1..6 name a chute; 0 and 7 carry no destination.
  function automatic logic grp_is_valid(input logic [2:0] g);
    return (g >= GRP1) && (g <= GRP6);
  endfunction

endpackage

// File: rtl/chute_gate_timer.sv
// Diverter gate hold timer: a fire pulse (re)loads the count, and the gate
// stays open while the count is nonzero.
module chute_gate_timer
  import sorter_pkg::*;
#(
  parameter int unsigned GATE_CYCLES = GATE_CYCLES_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic fire,
  output logic gate
);

  logic [TIMER_W-1:0] cnt_q, cnt_d;
  logic               gate_q, gate_d;

  // Retrigger reloads to the full hold time; it never extends beyond it.
  always_comb begin
    cnt_d = cnt_q;
    if (fire) begin
      cnt_d = TIMER_W'(GATE_CYCLES);
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - TIMER_W'(1);
    end
    gate_d = (cnt_d != '0);
  end

  always_ff @(negedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q  <= '0;
      gate_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      gate_q <= gate_d;
    end
  end

  assign gate = gate_q;

endmodule

// File: rtl/sort_gate_scheduler.sv
// Tracks classified packages along the belt in a small slot table and fires
// the matching chute diverter when each package reaches its chute.
module sort_gate_scheduler
  import sorter_pkg::*;
#(
  parameter int unsigned NSLOTS      = 4,
  parameter int unsigned D1          = D1_DEF,
  parameter int unsigned D2          = D2_DEF,
  parameter int unsigned D3          = D3_DEF,
  parameter int unsigned D4          = D4_DEF,
  parameter int unsigned D5          = D5_DEF,
  parameter int unsigned D6          = D6_DEF,
  parameter int unsigned GATE_CYCLES = GATE_CYCLES_DEF
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         grp_valid,
  input  logic [2:0]   grp_in,
  input  logic         tick,
  output logic [5:0]   gate,
  output logic [3:0]   occupancy,
  output logic         belt_stop,
  output logic         overflow
);

  localparam int unsigned IDX_W = (NSLOTS > 1) ? $clog2(NSLOTS) : 1;
  localparam int unsigned OCC_W = 4;

  slot_t              slot_q [NSLOTS];
  slot_t              slot_d [NSLOTS];
  logic [OCC_W-1:0]   occ_q, occ_d;
  logic               stop_q, stop_d;
  logic               ovf_q, ovf_d;
  logic [NCHUTES-1:0] fire_c;
  logic               accept_c;
  logic               alloc_hit_c;
  logic [IDX_W-1:0]   alloc_idx_c;

  function automatic logic [STEP_W-1:0] dist_of(input logic [2:0] g);
    case (g)
      GRP1:    return STEP_W'(D1);
      GRP2:    return STEP_W'(D2);
      GRP3:    return STEP_W'(D3);
      GRP4:    return STEP_W'(D4);
      GRP5:    return STEP_W'(D5);
      GRP6:    return STEP_W'(D6);
      default: return '0;
    endcase
  endfunction

  // Slot table update: tick/arrival on current slots, then allocation.
  // The free search uses pre-edge state, so a slot freed by an arrival on
  // this edge is not handed out again until the next edge.
  always_comb begin
    slot_d      = slot_q;
    fire_c      = '0;
    alloc_hit_c = 1'b0;
    alloc_idx_c = '0;
    accept_c    = grp_valid && grp_is_valid(grp_in);
    ovf_d       = ovf_q;
    occ_d       = '0;

    for (int i = int'(NSLOTS) - 1; i >= 0; i--) begin
      if (!slot_q[i].valid) begin
        alloc_hit_c = 1'b1;
        alloc_idx_c = IDX_W'(i);
      end
    end

    for (int i = 0; i < int'(NSLOTS); i++) begin
      if (slot_q[i].valid && tick) begin
        if (slot_q[i].steps == STEP_W'(1)) begin
          slot_d[i].valid = 1'b0;
          slot_d[i].steps = '0;
          for (int g = 0; g < int'(NCHUTES); g++) begin
            if (slot_q[i].grp == 3'(g + 1)) begin
              fire_c[g] = 1'b1;
            end
          end
        end else begin
          slot_d[i].steps = slot_q[i].steps - STEP_W'(1);
        end
      end
    end

    // A fresh slot holds its full distance even when a tick shares the edge.
    if (accept_c) begin
      if (alloc_hit_c) begin
        slot_d[alloc_idx_c].valid = 1'b1;
        slot_d[alloc_idx_c].grp   = grp_in;
        slot_d[alloc_idx_c].steps = dist_of(grp_in);
      end else begin
        ovf_d = 1'b1;
      end
    end

    for (int i = 0; i < int'(NSLOTS); i++) begin
      occ_d = occ_d + OCC_W'(slot_d[i].valid);
    end
    stop_d = (occ_d == OCC_W'(NSLOTS));
  end

  always_ff @(negedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < int'(NSLOTS); i++) begin
        slot_q[i] <= '0;
      end
      occ_q  <= '0;
      stop_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      for (int i = 0; i < int'(NSLOTS); i++) begin
        slot_q[i] <= slot_d[i];
      end
      occ_q  <= occ_d;
      stop_q <= stop_d;
      ovf_q  <= ovf_d;
    end
  end

  for (genvar g = 0; g < NCHUTES; g++) begin : g_chute
    chute_gate_timer #(
      .GATE_CYCLES(GATE_CYCLES)
    ) u_timer (
      .clk   (clk),
      .reset (reset),
      .fire  (fire_c[g]),
      .gate  (gate[g])
    );
  end

  assign occupancy = occ_q;
  assign belt_stop = stop_q;
  assign overflow  = ovf_q;

endmodule

// File: tb/tb_sort_gate_scheduler.sv
// Directed bench for sort_gate_scheduler: hand-computed expectations for
// allocation, arrival order, overflow, tick/alloc overlap, reset and retrigger.
module tb_sort_gate_scheduler;

  logic       clk;
  logic       reset;
  logic       grp_valid;
  logic [2:0] grp_in;
  logic       tick;
  logic [5:0] gate;
  logic [3:0] occupancy;
  logic       belt_stop;
  logic       overflow;

  int checks = 0;
  int errors = 0;

  sort_gate_scheduler dut (
    .clk       (clk),
    .reset     (reset),
    .grp_valid (grp_valid),
    .grp_in    (grp_in),
    .tick      (tick),
    .gate      (gate),
    .occupancy (occupancy),
    .belt_stop (belt_stop),
    .overflow  (overflow)
  );

  initial clk = 1'b1;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Drive on the rising edge; the DUT acts on the falling edge; return just after it.
  task automatic cyc(input logic v, input logic [2:0] g, input logic t);
    @(posedge clk);
    grp_valid = v;
    grp_in    = g;
    tick      = t;
    @(negedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 3'd0, 1'b0);
  endtask

  initial begin
    reset     = 1'b0;
    grp_valid = 1'b0;
    grp_in    = 3'd0;
    tick      = 1'b0;
    #22;
    check("rst_gate", 32'(gate), 32'h0);
    check("rst_occ", 32'(occupancy), 32'h0);
    check("rst_stop", 32'(belt_stop), 32'h0);
    check("rst_ovf", 32'(overflow), 32'h0);
    @(posedge clk);
    reset = 1'b1;

    // 1: single grp1 package, ticks two clocks apart
    cyc(1'b1, 3'd1, 1'b0);
    check("t1_occ_alloc", 32'(occupancy), 32'd1);
    for (int k = 1; k <= 3; k++) begin
      cyc(1'b0, 3'd0, 1'b1);
      check("t1_occ_travel", 32'(occupancy), 32'd1);
      check("t1_gate_travel", 32'(gate), 32'h0);
      idle(1);
    end
    cyc(1'b0, 3'd0, 1'b1);
    check("t1_occ_arrive", 32'(occupancy), 32'd0);
    check("t1_gate_p0", 32'(gate), 32'h01);
    idle(1);
    check("t1_gate_p1", 32'(gate), 32'h01);
    idle(1);
    check("t1_gate_p2", 32'(gate), 32'h01);
    idle(1);
    check("t1_gate_off", 32'(gate), 32'h0);

    // 2: out-of-order arrival, grp1 overtakes grp6
    cyc(1'b1, 3'd6, 1'b0);
    check("t2_occ1", 32'(occupancy), 32'd1);
    cyc(1'b0, 3'd0, 1'b1);
    cyc(1'b0, 3'd0, 1'b1);
    cyc(1'b1, 3'd1, 1'b0);
    check("t2_occ2", 32'(occupancy), 32'd2);
    for (int k = 3; k <= 24; k++) begin
      cyc(1'b0, 3'd0, 1'b1);
      if (k == 5) check("t2_gate_t5", 32'(gate), 32'h0);
      if (k == 6) begin
        check("t2_gate_t6", 32'(gate), 32'h01);
        check("t2_occ_t6", 32'(occupancy), 32'd1);
      end
      if (k == 23) check("t2_gate_t23", 32'(gate), 32'h0);
      if (k == 24) begin
        check("t2_gate_t24", 32'(gate), 32'h20);
        check("t2_occ_t24", 32'(occupancy), 32'd0);
      end
    end
    idle(4);

    // 3: fill the table, overflow, drain
    cyc(1'b1, 3'd2, 1'b0);
    cyc(1'b1, 3'd3, 1'b0);
    cyc(1'b1, 3'd4, 1'b0);
    check("t3_stop_lo", 32'(belt_stop), 32'h0);
    cyc(1'b1, 3'd5, 1'b0);
    check("t3_occ_full", 32'(occupancy), 32'd4);
    check("t3_stop_hi", 32'(belt_stop), 32'h1);
    check("t3_ovf_lo", 32'(overflow), 32'h0);
    cyc(1'b1, 3'd1, 1'b0);
    check("t3_occ_drop", 32'(occupancy), 32'd4);
    check("t3_ovf_hi", 32'(overflow), 32'h1);
    for (int k = 1; k <= 20; k++) begin
      cyc(1'b0, 3'd0, 1'b1);
      if (k == 8) begin
        check("t3_gate_t8", 32'(gate), 32'h02);
        check("t3_occ_t8", 32'(occupancy), 32'd3);
        check("t3_stop_t8", 32'(belt_stop), 32'h0);
      end
      if (k == 12) check("t3_gate_t12", 32'(gate), 32'h04);
    end
    check("t3_occ_drain", 32'(occupancy), 32'd0);
    check("t3_ovf_sticky", 32'(overflow), 32'h1);
    idle(4);

    // 4: allocation and tick on the same edge
    cyc(1'b1, 3'd2, 1'b1);
    check("t4_occ", 32'(occupancy), 32'd1);
    for (int k = 1; k <= 8; k++) begin
      cyc(1'b0, 3'd0, 1'b1);
      if (k == 7) begin
        check("t4_gate_t7", 32'(gate), 32'h0);
        check("t4_occ_t7", 32'(occupancy), 32'd1);
      end
      if (k == 8) begin
        check("t4_gate_t8", 32'(gate), 32'h02);
        check("t4_occ_t8", 32'(occupancy), 32'd0);
      end
    end
    idle(4);

    // 5: asynchronous reset with a package pending and a gate open
    cyc(1'b1, 3'd3, 1'b0);
    cyc(1'b0, 3'd0, 1'b1);
    cyc(1'b1, 3'd1, 1'b0);
    for (int k = 2; k <= 5; k++) cyc(1'b0, 3'd0, 1'b1);
    check("t5_gate_pre", 32'(gate), 32'h01);
    check("t5_occ_pre", 32'(occupancy), 32'd1);
    #2;
    reset = 1'b0;
    #1;
    check("t5_gate_rst", 32'(gate), 32'h0);
    check("t5_occ_rst", 32'(occupancy), 32'd0);
    check("t5_stop_rst", 32'(belt_stop), 32'h0);
    check("t5_ovf_rst", 32'(overflow), 32'h0);
    @(posedge clk);
    @(posedge clk);
    reset = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      cyc(1'b0, 3'd0, 1'b1);
      check("t5_gate_quiet", 32'(gate), 32'h0);
    end
    check("t5_occ_quiet", 32'(occupancy), 32'd0);

    // 6: ignored groups, then retrigger of chute 1
    cyc(1'b1, 3'd0, 1'b0);
    check("t6_occ_g0", 32'(occupancy), 32'd0);
    check("t6_ovf_g0", 32'(overflow), 32'h0);
    cyc(1'b1, 3'd7, 1'b0);
    check("t6_occ_g7", 32'(occupancy), 32'd0);
    check("t6_ovf_g7", 32'(overflow), 32'h0);
    cyc(1'b1, 3'd1, 1'b0);
    cyc(1'b0, 3'd0, 1'b1);
    cyc(1'b1, 3'd1, 1'b0);
    check("t6_occ2", 32'(occupancy), 32'd2);
    cyc(1'b0, 3'd0, 1'b1);
    cyc(1'b0, 3'd0, 1'b1);
    check("t6_gate_pre", 32'(gate), 32'h0);
    cyc(1'b0, 3'd0, 1'b1);
    check("t6_gate_a", 32'(gate), 32'h01);
    check("t6_occ_a", 32'(occupancy), 32'd1);
    cyc(1'b0, 3'd0, 1'b1);
    check("t6_gate_b", 32'(gate), 32'h01);
    check("t6_occ_b", 32'(occupancy), 32'd0);
    idle(1);
    check("t6_gate_h2", 32'(gate), 32'h01);
    idle(1);
    check("t6_gate_h3", 32'(gate), 32'h01);
    idle(1);
    check("t6_gate_off", 32'(gate), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
